// File: rtl/tipi_mailbox_core.sv
// ----------------------------------------------------------------------------
// tipi_mailbox_core : NCHAN-channel TI<->Pi byte mailbox with strobed nibble bus.
// Optional feature macro: TIPI_EXTINT_EN (registered TI interrupt on RC change).
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tipi_mailbox_core #(
  parameter int          NCHAN       = 1,
  parameter logic [15:0] CH_BASE     = 16'h5FF8,
  parameter int          NIB_W       = 4,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cru_dev_en,
  input  logic             cru_int_en,
  input  logic [0:15]      ti_a,
  input  logic             ti_memen,
  input  logic             ti_we,
  input  logic             ti_dbin,
  input  logic [7:0]       ti_d_in,
  output logic [7:0]       ti_d_out,
  output logic             ti_d_oe,
  output logic             ti_extint_n,
  input  logic             r_clk,
  input  logic             r_nibrst,
  input  logic [NIB_W-1:0] r_nib_in,
  output logic [NIB_W-1:0] r_nib_out,
  output logic             r_nib_oe
);

  localparam int         C_SPB      = 8 / NIB_W;
  localparam int         C_CH_SLOTS = 4 * C_SPB;
  localparam int         C_TOTAL    = C_CH_SLOTS * NCHAN;
  localparam int         C_PTR_W    = $clog2(C_TOTAL + 1);
  localparam logic [4:0] C_SYNC_RST = 5'b11000;

  // Async inputs packed as {ti_we, ti_memen, ti_dbin, r_clk, r_nibrst}
  logic [4:0] sync_q [SYNC_STAGES];
  logic [2:0] prev_q;
  logic       we_s, memen_s, dbin_s, rclk_s, nibrst_s;
  logic       we_fall, dbin_fall, rclk_rise;

  logic [7:0]         td_q [NCHAN], td_d [NCHAN];
  logic [7:0]         tc_q [NCHAN], tc_d [NCHAN];
  logic [7:0]         rd_q [NCHAN], rd_d [NCHAN];
  logic [7:0]         rc_q [NCHAN], rc_d [NCHAN];
  logic [NCHAN-1:0]   rc_changed_q, rc_changed_d;
  logic [NCHAN-1:0]   rd_pend_q, rd_pend_d;
  logic [C_PTR_W-1:0] ptr_q, ptr_d;
  logic               frame_q, frame_d;
  logic [15:0]        rsh_q, rsh_d;
  logic [15:0]        wsh_q, wsh_d;

  logic [15:0]      addr;
  logic [15:0]      base [NCHAN];
  logic             rd_qual;
  logic             hit;
  logic [7:0]       rdat;
  logic [NCHAN-1:0] rc_hit;
  logic [15:0]      wsh_next;
  int               ptr_i, cur_ch, cur_slot, nxt_ch;

  assign addr = ti_a;

  genvar gc;
  generate
    for (gc = 0; gc < NCHAN; gc++) begin : g_ch
      assign base[gc] = CH_BASE - 16'(8 * gc);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= C_SYNC_RST;
      prev_q <= 3'b100;
    end else begin
      sync_q[0] <= {ti_we, ti_memen, ti_dbin, r_clk, r_nibrst};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= {we_s, dbin_s, rclk_s};
    end
  end

  assign {we_s, memen_s, dbin_s, rclk_s, nibrst_s} = sync_q[SYNC_STAGES-1];
  assign we_fall   = prev_q[2] & ~we_s;
  assign dbin_fall = prev_q[1] & ~dbin_s;
  assign rclk_rise = ~prev_q[0] & rclk_s;

  // TI read path is purely combinational on the raw bus strobes
  always_comb begin
    rd_qual = cru_dev_en & ~ti_memen & ti_dbin;
    hit     = 1'b0;
    rdat    = 8'h00;
    rc_hit  = '0;
    for (int c = 0; c < NCHAN; c++) begin
      if (addr == base[c] + 16'd1) begin hit = 1'b1; rdat = rc_q[c]; rc_hit[c] = rd_qual; end
      if (addr == base[c] + 16'd3) begin hit = 1'b1; rdat = rd_q[c]; end
      if (addr == base[c] + 16'd5) begin hit = 1'b1; rdat = tc_q[c]; end
      if (addr == base[c] + 16'd7) begin hit = 1'b1; rdat = td_q[c]; end
    end
    ti_d_oe  = rd_qual & hit;
    ti_d_out = hit ? rdat : 8'h00;
  end

  always_comb begin
    ptr_i     = int'(ptr_q);
    cur_ch    = ptr_i / C_CH_SLOTS;
    cur_slot  = ptr_i % C_CH_SLOTS;
    nxt_ch    = (ptr_i + 1) / C_CH_SLOTS;
    r_nib_oe  = frame_q & ~nibrst_s & (ptr_i < C_TOTAL) & (cur_slot < 2 * C_SPB);
    r_nib_out = '0;
    for (int k = 0; k < 2 * C_SPB; k++) begin
      if (r_nib_oe && k == cur_slot) r_nib_out = rsh_q[16 - NIB_W * (k + 1) +: NIB_W];
    end
  end

  always_comb begin
    td_d         = td_q;
    tc_d         = tc_q;
    rd_d         = rd_q;
    rc_d         = rc_q;
    rc_changed_d = rc_changed_q;
    rd_pend_d    = rd_pend_q;
    ptr_d        = ptr_q;
    frame_d      = frame_q;
    rsh_d        = rsh_q;
    wsh_d        = wsh_q;
    wsh_next     = {wsh_q[15-NIB_W:0], r_nib_in};

    if (we_fall && !memen_s && cru_dev_en) begin
      for (int c = 0; c < NCHAN; c++) begin
        if (addr == base[c] + 16'd7) td_d[c] = ti_d_in;
        if (addr == base[c] + 16'd5) tc_d[c] = ti_d_in;
      end
    end

    // RC reads are remembered until DBIN drops, since the address is gone by then
    if (dbin_fall) begin
      rc_changed_d = rc_changed_q & ~rd_pend_q;
      rd_pend_d    = '0;
    end
    rd_pend_d = rd_pend_d | rc_hit;

    if (nibrst_s) begin
      ptr_d   = '0;
      frame_d = 1'b1;
      wsh_d   = '0;
      rsh_d   = {td_q[0], tc_q[0]};
    end else if (rclk_rise && frame_q && ptr_i < C_TOTAL) begin
      ptr_d = ptr_q + C_PTR_W'(1);
      if (cur_slot >= 2 * C_SPB) begin
        wsh_d = wsh_next;
        if (cur_slot == C_CH_SLOTS - 1) begin
          for (int c = 0; c < NCHAN; c++) begin
            if (c == cur_ch) begin
              rd_d[c] = wsh_next[15:8];
              rc_d[c] = wsh_next[7:0];
              if (wsh_next[7:0] != rc_q[c]) rc_changed_d[c] = 1'b1;
            end
          end
        end
      end
      if (((ptr_i + 1) % C_CH_SLOTS == 0) && (ptr_i + 1 < C_TOTAL)) begin
        for (int c = 0; c < NCHAN; c++) begin
          if (c == nxt_ch) rsh_d = {td_q[c], tc_q[c]};
        end
      end
    end
  end

  // frame_q stays low until the Pi issues its first frame reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCHAN; c++) begin
        td_q[c] <= 8'h00;
        tc_q[c] <= 8'h00;
        rd_q[c] <= 8'h00;
        rc_q[c] <= 8'h00;
      end
      rc_changed_q <= '0;
      rd_pend_q    <= '0;
      ptr_q        <= '0;
      frame_q      <= 1'b0;
      rsh_q        <= '0;
      wsh_q        <= '0;
    end else begin
      td_q         <= td_d;
      tc_q         <= tc_d;
      rd_q         <= rd_d;
      rc_q         <= rc_d;
      rc_changed_q <= rc_changed_d;
      rd_pend_q    <= rd_pend_d;
      ptr_q        <= ptr_d;
      frame_q      <= frame_d;
      rsh_q        <= rsh_d;
      wsh_q        <= wsh_d;
    end
  end

`ifdef TIPI_EXTINT_EN
  logic extint_q;
  always_ff @(posedge clk) begin
    if (rst) extint_q <= 1'b1;
    else     extint_q <= ~(cru_int_en & |rc_changed_q);
  end
  assign ti_extint_n = extint_q;
`else
  logic unused_int_en;
  assign unused_int_en = cru_int_en;
  assign ti_extint_n   = 1'b1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tipi_mailbox_core.sv
// ----------------------------------------------------------------------------
// tb_tipi_mailbox_core : directed self-checking bench, NCHAN=2, NIB_W=4.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_tipi_mailbox_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        cru_dev_en, cru_int_en;
  logic [15:0] ti_a;
  logic        ti_memen, ti_we, ti_dbin;
  logic [7:0]  ti_d_in, ti_d_out;
  logic        ti_d_oe, ti_extint_n;
  logic        r_clk, r_nibrst;
  logic [3:0]  r_nib_in, r_nib_out;
  logic        r_nib_oe;

  int total = 0;
  int bad   = 0;
  logic [7:0] rd_d;
  logic       rd_oe;
  logic       exp_int;

  tipi_mailbox_core #(
    .NCHAN(2), .CH_BASE(16'h5FF8), .NIB_W(4), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst), .cru_dev_en(cru_dev_en), .cru_int_en(cru_int_en),
    .ti_a(ti_a), .ti_memen(ti_memen), .ti_we(ti_we), .ti_dbin(ti_dbin),
    .ti_d_in(ti_d_in), .ti_d_out(ti_d_out), .ti_d_oe(ti_d_oe),
    .ti_extint_n(ti_extint_n), .r_clk(r_clk), .r_nibrst(r_nibrst),
    .r_nib_in(r_nib_in), .r_nib_out(r_nib_out), .r_nib_oe(r_nib_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ti_write(input logic [15:0] a, input logic [7:0] d);
    ti_a = a; ti_d_in = d; ti_memen = 1'b0;
    tick(1);
    ti_we = 1'b0;
    tick(6);
    ti_we = 1'b1;
    tick(1);
    ti_memen = 1'b1;
    tick(3);
  endtask

  task automatic ti_read(input logic [15:0] a, output logic [7:0] d, output logic oe);
    ti_a = a; ti_memen = 1'b0; ti_dbin = 1'b1;
    tick(2);
    d = ti_d_out; oe = ti_d_oe;
    ti_dbin = 1'b0; ti_memen = 1'b1;
    tick(4);
  endtask

  task automatic chk_reg(input string tag, input logic [15:0] a, input logic [7:0] exp);
    logic [7:0] d;
    logic       oe;
    ti_read(a, d, oe);
    chk(tag, {7'd0, oe, d}, {7'd0, 1'b1, exp});
  endtask

  task automatic chk_slot(input string tag, input logic oe, input logic [3:0] nib);
    chk(tag, {11'd0, r_nib_oe, r_nib_out}, {11'd0, oe, nib});
  endtask

  task automatic pi_pulse(input logic [3:0] n);
    r_nib_in = n;
    tick(1);
    r_clk = 1'b1;
    tick(4);
    r_clk = 1'b0;
    tick(4);
  endtask

  task automatic pi_frame_reset();
    r_nibrst = 1'b1;
    tick(4);
    r_nibrst = 1'b0;
    tick(4);
  endtask

  initial begin
`ifdef TIPI_EXTINT_EN
    exp_int = 1'b0;
`else
    exp_int = 1'b1;
`endif
    rst = 1'b1; cru_dev_en = 1'b1; cru_int_en = 1'b1;
    ti_a = 16'h0000; ti_memen = 1'b1; ti_we = 1'b1; ti_dbin = 1'b0; ti_d_in = 8'h00;
    r_clk = 1'b0; r_nibrst = 1'b0; r_nib_in = 4'h0;

    // Reset state
    tick(3);
    chk("rst_ti_d_oe",  16'(ti_d_oe), 16'd0);
    chk("rst_r_nib_oe", 16'(r_nib_oe), 16'd0);
    chk("rst_extint",   16'(ti_extint_n), 16'd1);
    rst = 1'b0;
    tick(2);
    chk("rst_nib_oe_idle", 16'(r_nib_oe), 16'd0);
    chk_reg("rst_rc0", 16'h5FF9, 8'h00);
    chk_reg("rst_rd0", 16'h5FFB, 8'h00);
    chk_reg("rst_tc0", 16'h5FFD, 8'h00);
    chk_reg("rst_td0", 16'h5FFF, 8'h00);

    // TI writes, Pi reads TD then TC MSB nibble first
    ti_write(16'h5FFF, 8'hA5);
    ti_write(16'h5FFD, 8'h3C);
    chk_reg("td0_a5", 16'h5FFF, 8'hA5);
    pi_frame_reset();
    chk_slot("f1_s0", 1'b1, 4'hA); pi_pulse(4'h0);
    chk_slot("f1_s1", 1'b1, 4'h5); pi_pulse(4'h0);
    chk_slot("f1_s2", 1'b1, 4'h3); pi_pulse(4'h0);
    chk_slot("f1_s3", 1'b1, 4'hC); pi_pulse(4'h0);
    chk_slot("f1_s4_wr", 1'b0, 4'h0);

    // Pi writes RD/RC; commit only after last write slot
    pi_pulse(4'h1); pi_pulse(4'h2); pi_pulse(4'hF);
    chk_reg("rd0_before_commit", 16'h5FFB, 8'h00);
    chk_reg("rc0_before_commit", 16'h5FF9, 8'h00);
    pi_pulse(4'hE);
    chk_reg("rd0_commit", 16'h5FFB, 8'h12);
    chk("rc_changed_set", 16'(dut.rc_changed_q[0]), 16'd1);
    chk("extint_on_change", 16'(ti_extint_n), 16'(exp_int));
    chk_reg("rc0_commit", 16'h5FF9, 8'hFE);
    tick(2);
    chk("rc_changed_clr", 16'(dut.rc_changed_q[0]), 16'd0);
    chk("extint_after_clr", 16'(ti_extint_n), 16'd1);

    // Channel 1 access and its slots
    ti_write(16'h5FF7, 8'h77);
    chk_reg("td1_77", 16'h5FF7, 8'h77);
    chk_reg("td0_kept", 16'h5FFF, 8'hA5);
    pi_frame_reset();
    repeat (4) pi_pulse(4'h0);
    pi_pulse(4'h1); pi_pulse(4'h2); pi_pulse(4'hF); pi_pulse(4'hE);
    chk("rc_same_no_set", 16'(dut.rc_changed_q[0]), 16'd0);
    chk_slot("f2_s8", 1'b1, 4'h7); pi_pulse(4'h0);
    chk_slot("f2_s9", 1'b1, 4'h7); pi_pulse(4'h0);
    chk_slot("f2_s10", 1'b1, 4'h0); pi_pulse(4'h0);
    chk_slot("f2_s11", 1'b1, 4'h0); pi_pulse(4'h0);
    pi_pulse(4'h4); pi_pulse(4'hB); pi_pulse(4'h0); pi_pulse(4'h0);
    chk("ptr_at_total", 16'(dut.ptr_q), 16'd16);
    chk_slot("idle_oe", 1'b0, 4'h0);
    pi_pulse(4'h5);
    chk("ptr_saturate", 16'(dut.ptr_q), 16'd16);
    chk_reg("rd1_4b", 16'h5FF3, 8'h4B);
    chk_reg("rc1_00", 16'h5FF1, 8'h00);

    // Frame reset in the middle of a write phase
    pi_frame_reset();
    repeat (4) pi_pulse(4'h0);
    pi_pulse(4'h9); pi_pulse(4'h9);
    r_nibrst = 1'b1;
    tick(4);
    chk("nibrst_ptr0", 16'(dut.ptr_q), 16'd0);
    chk_slot("nibrst_oe0", 1'b0, 4'h0);
    r_nibrst = 1'b0;
    tick(4);
    chk_reg("rd0_unchanged", 16'h5FFB, 8'h12);
    chk_reg("rc0_unchanged", 16'h5FF9, 8'hFE);
    chk_slot("f3_s0", 1'b1, 4'hA);

    // TI write of TC during the read phase: old pair now, new pair next frame
    pi_pulse(4'h0); pi_pulse(4'h0);
    ti_write(16'h5FFD, 8'h99);
    chk_slot("f3_s2_old", 1'b1, 4'h3); pi_pulse(4'h0);
    chk_slot("f3_s3_old", 1'b1, 4'hC); pi_pulse(4'h0);
    pi_pulse(4'h1); pi_pulse(4'h2); pi_pulse(4'hF); pi_pulse(4'hE);
    pi_frame_reset();
    chk_slot("f4_s0", 1'b1, 4'hA); pi_pulse(4'h0);
    chk_slot("f4_s1", 1'b1, 4'h5); pi_pulse(4'h0);
    chk_slot("f4_s2_new", 1'b1, 4'h9); pi_pulse(4'h0);
    chk_slot("f4_s3_new", 1'b1, 4'h9);

    // Device disabled: write ignored, no bus drive
    cru_dev_en = 1'b0;
    ti_write(16'h5FFF, 8'h11);
    ti_read(16'h5FFF, rd_d, rd_oe);
    chk("dev_off_oe", 16'(rd_oe), 16'd0);
    cru_dev_en = 1'b1;
    chk_reg("dev_off_no_write", 16'h5FFF, 8'hA5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
